// File: rtl/halfadd.sv
// halfadd: single-bit half adder with combinational and registered result paths.
// Define HALFADD_STATS_EN to build the saturating carry-event counter on carry_cnt.
module halfadd #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             s,
    output logic             c,
    output logic             s_q,
    output logic             c_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] carry_cnt
);

    assign s = a ^ b;
    assign c = a & b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 1'b0;
            c_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s;
            c_q     <= c;
            valid_q <= 1'b1;
        end
    end

`ifdef HALFADD_STATS_EN
    logic [CNT_W-1:0] cnt;
    logic             sat;

    assign sat = &cnt;

    // Adding the carry bit directly lets an unknown carry show up in the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(c & ~sat);
        end
    end

    assign carry_cnt = cnt;
`else
    assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_halfadd.sv
// tb_halfadd: random and directed stimulus for halfadd against a behavioural model.
// Build with or without HALFADD_STATS_EN; counter expectations follow the macro.
module tb_halfadd;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             clk_en = 1'b1;
    logic             rst;
    logic             a;
    logic             b;
    logic             s;
    logic             c;
    logic             s_q;
    logic             c_q;
    logic             valid_q;
    logic [CNT_W-1:0] carry_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // model state
    int m_s   = 0;
    int m_c   = 0;
    int m_v   = 0;
    int m_cnt = 0;

    halfadd #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .s         (s),
        .c         (c),
        .s_q       (s_q),
        .c_q       (c_q),
        .valid_q   (valid_q),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: arithmetic sum of the two bits, split into sum and carry digits.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s   = 0;
            m_c   = 0;
            m_v   = 0;
            m_cnt = 0;
        end else begin
            int sum;
            sum = int'(a) + int'(b);
            m_s = sum % 2;
            m_c = sum / 2;
            m_v = 1;
`ifdef HALFADD_STATS_EN
            if (m_c == 1 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
        end
    end

    // Compare process: all outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int sum;
            sum = int'(a) + int'(b);
            chk("cmp_s", 32'(s), 32'(sum % 2));
            chk("cmp_c", 32'(c), 32'(sum / 2));
            chk("cmp_s_q", 32'(s_q), 32'(m_s));
            chk("cmp_c_q", 32'(c_q), 32'(m_c));
            chk("cmp_valid_q", 32'(valid_q), 32'(m_v));
            chk("cmp_carry_cnt", 32'(carry_cnt), 32'(m_cnt));
        end
    end

    // a,b pairs (a in bit 1) and the expected {s,c} for each
    logic [1:0] seq_ab [7] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0] seq_sc [7] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
    logic [1:0] tt_sc  [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
`ifdef HALFADD_STATS_EN
    int sat_cnt [5] = '{1, 2, 3, 3, 3};
`else
    int sat_cnt [5] = '{0, 0, 0, 0, 0};
`endif

    initial begin
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        #3;
        // reset state, literal
        chk("rst_s", 32'(s), 0);
        chk("rst_c", 32'(c), 0);
        chk("rst_s_q", 32'(s_q), 0);
        chk("rst_c_q", 32'(c_q), 0);
        chk("rst_valid_q", 32'(valid_q), 0);
        chk("rst_carry_cnt", 32'(carry_cnt), 0);
        @(negedge clk);
        #1 chk_en = 1'b1;
        rst = 1'b0;

        // directed sequence, literal expectations
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("seq_s_q", 32'(s_q), 32'(seq_sc[i-1][1]));
                chk("seq_c_q", 32'(c_q), 32'(seq_sc[i-1][0]));
            end
            #1;
            a = seq_ab[i][1];
            b = seq_ab[i][0];
            #1;
            $display("[TB] a=%b b=%b s=%b c=%b", a, b, s, c);
            chk("seq_s", 32'(s), 32'(seq_sc[i][1]));
            chk("seq_c", 32'(c), 32'(seq_sc[i][0]));
        end
        @(negedge clk);
        chk("seq_s_q", 32'(s_q), 32'(seq_sc[6][1]));
        chk("seq_c_q", 32'(c_q), 32'(seq_sc[6][0]));

        // clock stopped: combinational path alive, registers frozen at 11 -> 01
        clk_en = 1'b0;
        #20;
        for (int i = 0; i < 4; i++) begin
            a = 1'(i >> 1);
            b = 1'(i);
            #1;
            chk("stop_s", 32'(s), 32'(tt_sc[i][1]));
            chk("stop_c", 32'(c), 32'(tt_sc[i][0]));
            chk("stop_s_q", 32'(s_q), 0);
            chk("stop_c_q", 32'(c_q), 1);
            #4;
        end
        clk_en = 1'b1;

        // saturation with a=b=1 held
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        a = 1'b1;
        b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("sat_cnt", 32'(carry_cnt), 32'(sat_cnt[k]));
            chk("sat_c_q", 32'(c_q), 1);
            chk("sat_s_q", 32'(s_q), 0);
        end

        // asynchronous reset between edges with count at 2
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_cnt_pre", 32'(carry_cnt), 32'(sat_cnt[1]));
        #3 rst = 1'b1;
        #1;
        chk("mid_s_q", 32'(s_q), 0);
        chk("mid_c_q", 32'(c_q), 0);
        chk("mid_valid_q", 32'(valid_q), 0);
        chk("mid_carry_cnt", 32'(carry_cnt), 0);
        chk("mid_c", 32'(c), 1);
        chk("mid_s", 32'(s), 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // randomized traffic with occasional mid-cycle reset pulses
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            rst = 1'b0;
            a   = 1'($urandom);
            b   = 1'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
